// File: rtl/ysyx_23060171_ifu_pc_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060171_ifu_pc_pkg
//   Shared encodings for the fetch unit and the decode stage:
//     - pcsrc_e        : next-PC select code driven by decode/execute
//     - fetch_state_e  : fetch sequencer states
//     - pc_misaligned(): alignment test applied to every computed next PC
// ---------------------------------------------------------------------------
package ysyx_23060171_ifu_pc_pkg;

  // Next-PC select. Codes 101..111 are unused and fall back to snpc.
  typedef enum logic [2:0] {
    PCSRC_SNPC   = 3'b000,
    PCSRC_DNPC   = 3'b001,
    PCSRC_DNPC_R = 3'b010,
    PCSRC_MTVEC  = 3'b011,
    PCSRC_MEPC   = 3'b100
  } pcsrc_e;

  // One instruction in flight: request, wait response, hand to decode,
  // wait for the next-PC update. HALT is terminal until reset.
  typedef enum logic [2:0] {
    REQ   = 3'd0,
    RSP   = 3'd1,
    ISSUE = 3'd2,
    UPD   = 3'd3,
    HALT  = 3'd4
  } fetch_state_e;

  localparam int INST_W = 32;

  // Instructions are 32-bit aligned; no compressed ISA support.
  function automatic logic pc_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_23060171_npc_mux.sv
// ---------------------------------------------------------------------------
// ysyx_23060171_npc_mux
//   Purely combinational next-PC selector.
//   Ports:
//     pc         in   current architectural PC
//     pc_src     in   3-bit select (pcsrc_e encoding)
//     dnpc       in   pc+imm target (branch / jal)
//     dnpc_r     in   rs1+imm target (jalr), bit0 cleared here
//     mtvec      in   trap vector
//     mepc       in   exception return PC
//     next       out  selected next PC
//     misaligned out  next[1:0] != 0
// ---------------------------------------------------------------------------
module ysyx_23060171_npc_mux
  import ysyx_23060171_ifu_pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      pc_src,
  input  logic [XLEN-1:0] dnpc,
  input  logic [XLEN-1:0] dnpc_r,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] next,
  output logic            misaligned
);

  logic [XLEN-1:0] snpc;

  // Wraps modulo 2^XLEN by construction.
  assign snpc = pc + XLEN'(4);

  always_comb begin
    next = snpc;
    case (pcsrc_e'(pc_src))
      PCSRC_SNPC:   next = snpc;
      PCSRC_DNPC:   next = dnpc;
      // jalr target ignores bit0 of rs1+imm.
      PCSRC_DNPC_R: next = dnpc_r & ~XLEN'(1);
      PCSRC_MTVEC:  next = mtvec;
      PCSRC_MEPC:   next = mepc;
      default:      next = snpc;
    endcase
  end

  assign misaligned = pc_misaligned(next[1:0]);

endmodule

// File: rtl/ysyx_23060171_ifu_pc.sv
// ---------------------------------------------------------------------------
// ysyx_23060171_ifu_pc
//   PC register and instruction-fetch sequencer for a multi-cycle core.
//   One instruction in flight: REQ -> RSP -> ISSUE -> UPD -> REQ.
//   Any fetch fault (response error, response timeout, misaligned next PC)
//   parks the block in HALT with fetch_err high until rst.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     upd_valid / upd_ready    next-PC update handshake from execute
//     pc_src, dnpc, dnpc_r,
//     mtvec, mepc              next-PC select and candidate targets
//     imem_req_*               fetch request (address = pc)
//     imem_rsp_*               fetch response (data, access fault)
//     inst_valid / inst_ready  instruction hand-off to decode
//     inst, inst_pc            fetched instruction and its PC
//     fetch_err                sticky fault flag
// ---------------------------------------------------------------------------
module ysyx_23060171_ifu_pc
  import ysyx_23060171_ifu_pc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
  parameter int              TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [2:0]        pc_src,
  input  logic [XLEN-1:0]   dnpc,
  input  logic [XLEN-1:0]   dnpc_r,
  input  logic [XLEN-1:0]   mtvec,
  input  logic [XLEN-1:0]   mepc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_rsp_valid,
  output logic              imem_rsp_ready,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              fetch_err
);

  // Counter only needs to reach TIMEOUT; a 1-bit stub when disabled.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
  logic              fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;

  // Ungated handshake outputs; forced low while rst is high below.
  logic req_valid_c, rsp_ready_c, inst_valid_c, upd_ready_c;

  logic [XLEN-1:0] npc;
  logic            npc_misaligned;

  ysyx_23060171_npc_mux #(
    .XLEN (XLEN)
  ) u_npc_mux (
    .pc         (pc_q),
    .pc_src     (pc_src),
    .dnpc       (dnpc),
    .dnpc_r     (dnpc_r),
    .mtvec      (mtvec),
    .mepc       (mepc),
    .next       (npc),
    .misaligned (npc_misaligned)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    fetch_err_d  = fetch_err_q;
    cnt_d        = cnt_q;
    req_valid_c  = 1'b0;
    rsp_ready_c  = 1'b0;
    inst_valid_c = 1'b0;
    upd_ready_c  = 1'b0;

    case (state_q)
      REQ: begin
        req_valid_c = 1'b1;
        if (imem_req_ready) begin
          state_d = RSP;
          cnt_d   = '0;
        end
      end

      RSP: begin
        rsp_ready_c = 1'b1;
        // A response in the same cycle as the timeout wins.
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            fetch_err_d = 1'b1;
            state_d     = HALT;
          end else begin
            inst_d    = imem_rsp_data;
            inst_pc_d = pc_q;
            state_d   = ISSUE;
          end
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            fetch_err_d = 1'b1;
            state_d     = HALT;
          end
        end
      end

      ISSUE: begin
        // inst/inst_pc are only written in RSP, so they hold while stalled.
        inst_valid_c = 1'b1;
        if (inst_ready) state_d = UPD;
      end

      UPD: begin
        upd_ready_c = 1'b1;
        if (upd_valid) begin
          // PC is loaded even when misaligned so the bad target is visible.
          pc_d = npc;
          if (npc_misaligned) begin
            fetch_err_d = 1'b1;
            state_d     = HALT;
          end else begin
            state_d = REQ;
          end
        end
      end

      HALT: begin
        fetch_err_d = 1'b1;
      end

      default: begin
        fetch_err_d = 1'b1;
        state_d     = HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      fetch_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      fetch_err_q <= fetch_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Reset abandons any in-flight transfer, so no handshake may complete
  // during the reset cycle.
  assign imem_req_valid = req_valid_c  & ~rst;
  assign imem_rsp_ready = rsp_ready_c  & ~rst;
  assign inst_valid     = inst_valid_c & ~rst;
  assign upd_ready      = upd_ready_c  & ~rst;

  assign imem_addr = pc_q;
  assign inst      = inst_q;
  assign inst_pc   = inst_pc_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_ysyx_23060171_ifu_pc.sv
module tb_ysyx_23060171_ifu_pc;

  logic        clk, rst;
  logic        upd_valid, upd_ready;
  logic [2:0]  pc_src;
  logic [31:0] dnpc, dnpc_r, mtvec, mepc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid, imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        fetch_err;

  // bench-side memory controls
  logic        rsp_en, err_en, pend;
  logic [31:0] mem_data;

  int n_vec = 0, n_err = 0;
  int cyc_n = 0, req_cnt = 0, upd_cnt = 0;
  int last_inst_cyc = 0, prev_inst_cyc = 0;

  logic [31:0] exp_addr[$];
  logic [63:0] exp_inst[$];   // {inst, inst_pc}

  ysyx_23060171_ifu_pc #(.XLEN(32), .RESET_PC(32'h8000_0000), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .pc_src(pc_src), .dnpc(dnpc), .dnpc_r(dnpc_r), .mtvec(mtvec), .mepc(mepc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s", nm);
  endtask

  // inputs change 2 time units after the rising edge; monitor samples on the falling edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // ---------------- memory model ----------------
  logic req_hs_s = 1'b0, rsp_hs_s = 1'b0;
  assign imem_rsp_valid = pend & rsp_en;
  assign imem_rsp_data  = mem_data;
  assign imem_rsp_err   = err_en;

  always @(posedge clk) begin
    if (rst)           pend <= 1'b0;
    else if (req_hs_s) pend <= 1'b1;
    else if (rsp_hs_s) pend <= 1'b0;
  end

  // ---------------- monitor / scoreboard ----------------
  logic        prev_req_stall = 1'b0, prev_inst_stall = 1'b0, issued = 1'b0;
  logic [31:0] prev_addr, prev_inst, prev_ipc;
  logic [63:0] e;

  always @(negedge clk) begin
    cyc_n++;
    req_hs_s = imem_req_valid && imem_req_ready;
    rsp_hs_s = imem_rsp_valid && imem_rsp_ready;
    if (rst) begin
      prev_req_stall  = 1'b0;
      prev_inst_stall = 1'b0;
      issued          = 1'b0;
    end else begin
      if (prev_req_stall) begin
        chk("req_valid_held", {31'b0, imem_req_valid}, 32'd1);
        chk("req_addr_stable", imem_addr, prev_addr);
      end
      if (prev_inst_stall) begin
        chk("inst_valid_held", {31'b0, inst_valid}, 32'd1);
        chk("inst_stable", inst, prev_inst);
        chk("inst_pc_stable", inst_pc, prev_ipc);
      end
      if (imem_req_valid && imem_req_ready) begin
        req_cnt++;
        if (exp_addr.size() == 0) fail_now($sformatf("unexpected_request addr=%h", imem_addr));
        else chk("imem_addr", imem_addr, exp_addr.pop_front());
      end
      if (inst_valid && inst_ready) begin
        if (exp_inst.size() == 0) fail_now($sformatf("unexpected_inst pc=%h", inst_pc));
        else begin
          e = exp_inst.pop_front();
          chk("inst", inst, e[63:32]);
          chk("inst_pc", inst_pc, e[31:0]);
        end
        prev_inst_cyc = last_inst_cyc;
        last_inst_cyc = cyc_n;
        issued = 1'b1;
      end else if (upd_ready) begin
        chk("upd_ready_after_issue", {31'b0, issued}, 32'd1);
        if (upd_valid) begin
          upd_cnt++;
          issued = 1'b0;
        end
      end
      prev_req_stall  = imem_req_valid && !imem_req_ready;
      prev_addr       = imem_addr;
      prev_inst_stall = inst_valid && !inst_ready;
      prev_inst       = inst;
      prev_ipc        = inst_pc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; imem_req_ready = 1'b0; rsp_en = 1'b1; err_en = 1'b0;
    inst_ready = 1'b1; upd_valid = 1'b1; pc_src = 3'b000;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_rsp_ready", {31'b0, imem_rsp_ready}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_upd_ready", {31'b0, upd_ready}, 32'd0);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic wait_upd();
    int n0 = upd_cnt;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (upd_cnt != n0) return;
    end
    fail_now("timeout_waiting_update");
  endtask

  task automatic wait_req();
    int n0 = req_cnt;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (req_cnt != n0) return;
    end
    fail_now("timeout_waiting_request");
  endtask

  task automatic setup(input logic [31:0] addr, input logic [31:0] data,
                       input logic [2:0] src, input logic [31:0] tgt);
    exp_addr.push_back(addr);
    exp_inst.push_back({data, addr});
    mem_data = data; pc_src = src;
    dnpc = tgt; dnpc_r = tgt; mtvec = tgt; mepc = tgt;
    // targets not selected get a poison value to catch a wrong mux leg
    if (src != 3'b001) dnpc   = 32'hdead_beec;
    if (src != 3'b010) dnpc_r = 32'hdead_bee8;
    if (src != 3'b011) mtvec  = 32'hdead_bee4;
    if (src != 3'b100) mepc   = 32'hdead_bee0;
    upd_valid = 1'b1; rsp_en = 1'b1;
  endtask

  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data,
                           input logic [2:0] src, input logic [31:0] tgt);
    setup(addr, data, src, tgt);
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    wait_upd();
  endtask

  task automatic fetch_bp(input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] src, input logic [31:0] tgt);
    bit seen;
    setup(addr, data, src, tgt);
    imem_req_ready = 1'b0; inst_ready = 1'b0;
    repeat (3) cyc();
    imem_req_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      if (inst_valid) seen = 1;
    end
    if (!seen) fail_now("timeout_waiting_inst_valid");
    imem_req_ready = 1'b0;
    repeat (5) cyc();
    inst_ready = 1'b1;
    wait_upd();
  endtask

  task automatic check_halted(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("halt_fetch_err", {31'b0, fetch_err}, 32'd1);
      chk("halt_outputs", {28'b0, imem_req_valid, imem_rsp_ready, inst_valid, upd_ready}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    bit seen;
    rst = 1'b1; upd_valid = 1'b0; pc_src = 3'b000; imem_req_ready = 1'b0;
    inst_ready = 1'b0; rsp_en = 1'b0; err_en = 1'b0; mem_data = '0;
    dnpc = '0; dnpc_r = '0; mtvec = '0; mepc = '0;

    // sequential flow, snpc, 4-cycle throughput
    do_reset();
    fetch_one(32'h8000_0000, 32'h0000_0013, 3'b000, 32'h0);
    fetch_one(32'h8000_0004, 32'h0000_0013, 3'b000, 32'h0);
    chk("throughput_1", last_inst_cyc - prev_inst_cyc, 32'd4);
    fetch_one(32'h8000_0008, 32'h0000_0013, 3'b000, 32'h0);
    chk("throughput_2", last_inst_cyc - prev_inst_cyc, 32'd4);
    // branch, jalr (bit0 cleared), trap, return
    fetch_one(32'h8000_000C, 32'h0100_006f, 3'b001, 32'h8000_0100);
    fetch_one(32'h8000_0100, 32'h0000_8067, 3'b010, 32'h8000_0201);
    fetch_one(32'h8000_0200, 32'h0000_0073, 3'b011, 32'h8000_1000);
    fetch_one(32'h8000_1000, 32'h3020_0073, 3'b100, 32'h8000_0008);
    // backpressure; unused select 101 behaves as snpc
    fetch_bp (32'h8000_0008, 32'h00a5_0513, 3'b101, 32'h0);
    fetch_one(32'h8000_000C, 32'h0000_0013, 3'b000, 32'h0);
    // misaligned branch target halts
    fetch_one(32'h8000_0010, 32'h0020_0063, 3'b001, 32'h8000_0102);
    check_halted(4);

    // response access fault
    do_reset();
    exp_addr.push_back(32'h8000_0000);
    err_en = 1'b1; imem_req_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      if (fetch_err) seen = 1;
    end
    if (!seen) fail_now("timeout_waiting_rsp_err");
    imem_req_ready = 1'b0; err_en = 1'b0;
    check_halted(5);

    // response timeout on the 8th RSP cycle
    do_reset();
    exp_addr.push_back(32'h8000_0000);
    rsp_en = 1'b0; imem_req_ready = 1'b1;
    wait_req();
    imem_req_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("rsp_wait_%0d_ready", k), {31'b0, imem_rsp_ready}, 32'd1);
      chk($sformatf("rsp_wait_%0d_err", k), {31'b0, fetch_err}, 32'd0);
    end
    check_halted(3);

    // response arrives on the cycle the timeout would fire: response wins
    do_reset();
    setup(32'h8000_0000, 32'h1234_5013, 3'b000, 32'h0);
    rsp_en = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    wait_req();
    imem_req_ready = 1'b0;
    repeat (7) cyc();
    rsp_en = 1'b1;
    wait_upd();
    @(negedge clk);
    chk("race_no_err", {31'b0, fetch_err}, 32'd0);

    // reset while a response is offered in RSP
    do_reset();
    exp_addr.push_back(32'h8000_0000);
    rsp_en = 1'b0; imem_req_ready = 1'b1;
    wait_req();
    imem_req_ready = 1'b0; rsp_en = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rstmid_rsp_ready", {31'b0, imem_rsp_ready}, 32'd0);
    chk("rstmid_inst_valid", {31'b0, inst_valid}, 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rstmid_addr", imem_addr, 32'h8000_0000);
    chk("rstmid_inst_valid2", {31'b0, inst_valid}, 32'd0);
    chk("rstmid_fetch_err", {31'b0, fetch_err}, 32'd0);

    cyc();
    chk("exp_addr_drained", exp_addr.size(), 32'd0);
    chk("exp_inst_drained", exp_inst.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_23060171_ifu_pc.md
Name: ysyx_23060171_ifu_pc

Overview:
- PC register and instruction-fetch sequencer for the single-issue, multi-cycle core.
- Holds the architectural PC and fetches one instruction over a valid/ready instruction-memory interface.
- Hands the instruction and its PC to the decode stage.
- Consumes the 3-bit PCSrc code produced by decode/execute to select the next PC.
- Only one instruction is in flight at a time.

Parameters:
- XLEN, 32, width of PC and address/data operands
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- TIMEOUT, 255, cycles to wait for a fetch response before declaring a fetch error (0 disables the timeout)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- upd_valid  in  1  next-PC information valid (instruction executed)
- upd_ready  out  1  block accepts next-PC information
- pc_src  in  3  next-PC select: 000 snpc, 001 dnpc, 010 dnpc_r, 011 mtvec, 100 mepc
- dnpc  in  XLEN  pc+imm target (branch/jal)
- dnpc_r  in  XLEN  rs1+imm target (jalr)
- mtvec  in  XLEN  trap vector CSR
- mepc  in  XLEN  exception PC CSR
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  XLEN  fetch address
- imem_rsp_valid  in  1  fetch response valid
- imem_rsp_ready  out  1  block accepts response
- imem_rsp_data  in  32  fetched instruction
- imem_rsp_err  in  1  access fault on the response
- inst_valid  out  1  instruction valid to decode
- inst_ready  in  1  decode accepts instruction
- inst  out  32  instruction to decode
- inst_pc  out  XLEN  PC of inst
- fetch_err  out  1  sticky fetch fault; the block is halted while it is high

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: pc=RESET_PC, state=REQ, inst=0, inst_pc=0, fetch_err=0, timeout counter=0. All valid/ready outputs are 0 during the reset cycle.
- State REQ:
  - imem_req_valid=1, imem_addr=pc.
  - On imem_req_ready go to RSP and clear the timeout counter.
- State RSP:
  - imem_rsp_ready=1.
  - On imem_rsp_valid with !imem_rsp_err: latch inst=imem_rsp_data and inst_pc=pc, go to ISSUE.
  - On imem_rsp_valid with imem_rsp_err: set fetch_err, go to HALT.
  - Otherwise increment the counter. When the counter reaches TIMEOUT (and TIMEOUT≠0): set fetch_err, go to HALT.
- State ISSUE:
  - inst_valid=1; inst and inst_pc are held stable while inst_valid is high and inst_ready is low.
  - On inst_ready go to UPD.
- State UPD:
  - upd_ready=1. On upd_valid, compute next PC from pc_src:
    - 000: pc+4
    - 001: dnpc
    - 010: dnpc_r with bit0 forced to 0
    - 011: mtvec
    - 100: mepc
    - 101-111: pc+4
  - If next[1:0]≠0: set fetch_err, go to HALT; pc is loaded anyway for debug visibility.
  - Otherwise load pc=next and go to REQ.
- State HALT: all valid/ready outputs 0, fetch_err=1, remain until rst.
- Handshake rules:
  - All handshakes complete on the cycle valid&ready is high at a rising edge.
  - The block never drops imem_req_valid or inst_valid once asserted until accepted.
- Ignored inputs:
  - upd_valid is ignored outside UPD.
  - imem_rsp_valid is ignored outside RSP, because imem_rsp_ready=0 there.
- Adder width: pc+4 wraps modulo 2^XLEN.
- Throughput: with zero-wait memory and always-ready decode, one instruction every 4 cycles (REQ, RSP, ISSUE, UPD).
- Reset mid-operation: state returns to REQ and pc to RESET_PC on the next edge. Any partially completed request or response is abandoned; the memory shares rst.
- Simultaneous events: in RSP, if a response arrives on the same cycle the counter would hit TIMEOUT, the response wins.

Decomposition:
- Shared package holds:
  - PCSrc encodings: PCSRC_SNPC, PCSRC_DNPC, PCSRC_DNPC_R, PCSRC_MTVEC, PCSRC_MEPC.
  - Fetch state encoding: REQ, RSP, ISSUE, UPD, HALT.
  - The decode stage uses the same PCSrc constants.
- One combinational sub-module, ysyx_23060171_npc_mux (pc, pc_src, dnpc, dnpc_r, mtvec, mepc → next, misaligned).
- The FSM, PC register and timeout counter stay in this block.

Test Plan:
1. Reset release, zero-wait memory returning 32'h0000_0013, pc_src=000 every update → fetch addresses 8000_0000, 8000_0004, 8000_0008; inst_valid every 4th cycle; inst_pc matches each address.
2. Branch taken: pc_src=001, dnpc=8000_0100 → next imem_addr=8000_0100. jalr: pc_src=010, dnpc_r=8000_0201 → next imem_addr=8000_0200.
3. Backpressure: imem_req_ready low 3 cycles, then inst_ready low 5 cycles → imem_addr, inst and inst_pc stay stable throughout; no duplicate request issued; upd_ready not asserted before the inst handshake.
4. Trap and return: pc_src=011 with mtvec=8000_1000, then pc_src=100 with mepc=8000_0008 → fetches at 8000_1000, then 8000_0008.
5. Faults:
   - imem_rsp_err=1 → fetch_err=1; all valid/ready outputs stay 0 until rst.
   - Separately, dnpc=8000_0102 with pc_src=001 → HALT with fetch_err=1.
   - Separately, TIMEOUT=8 with no response → fetch_err asserted on the 8th RSP cycle.
6. rst asserted while in RSP with a response arriving the same cycle → response ignored; next cycle state=REQ, imem_addr=8000_0000, inst_valid=0.
